// File: rtl/ex_sequencer.sv
// EX-stage sequencer for RV32IM: decodes ALU/MU/DU controls, holds one instruction
// in flight, launches multi-cycle MUL/DIV with a done watchdog, and hands off to MEM.
module ex_sequencer #(
  parameter int unsigned ifuresctl_N = 3,
  parameter int unsigned WAIT_MAX    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     func3,
  input  logic [1:0]                     func7b50,
  input  logic                           mul_done,
  input  logic                           div_done,
  output logic                           mul_start,
  output logic                           div_start,
  output logic [3:0]                     aluctl,
  output logic [1:0]                     mulctl,
  output logic [1:0]                     divctl,
  output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           err
);

  localparam int unsigned RW     = $clog2(ifuresctl_N);
  localparam int unsigned CW     = $clog2(WAIT_MAX + 1);
  localparam bit          DIV_OK = (ifuresctl_N >= 3);

  localparam logic [6:0]    OP_R     = 7'b0110011;
  localparam logic [6:0]    OP_IMM   = 7'b0010011;
  localparam logic [RW-1:0] SEL_ALU  = '0;
  localparam logic [RW-1:0] SEL_MU   = RW'(1);
  localparam logic [RW-1:0] SEL_DU   = RW'(DIV_OK ? 2 : 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    aluctl_q, aluctl_d;
  logic [1:0]    mulctl_q, mulctl_d;
  logic [1:0]    divctl_q, divctl_d;
  logic [RW-1:0] sel_q, sel_d;
  logic          err_q, err_d;
  logic          wdiv_q, wdiv_d;
  logic          mul_start_q, mul_start_d;
  logic          div_start_q, div_start_d;

  logic          is_mext, dec_mul, dec_div, accept;
  logic [3:0]    dec_alu;

  // alt selects sub (func3=000) or sra (func3=101)
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] r;
    case (f3)
      3'b000:  r = {3'b000, alt};
      3'b001:  r = 4'b0101;
      3'b010:  r = 4'b1000;
      3'b011:  r = 4'b1001;
      3'b100:  r = 4'b0010;
      3'b101:  r = {3'b011, alt};
      3'b110:  r = 4'b0011;
      default: r = 4'b0100;
    endcase
    return r;
  endfunction

  always_comb begin
    is_mext = (opcode == OP_R) && (func7b50 == 2'b01);
    dec_mul = is_mext && !func3[2];
    dec_div = is_mext && func3[2];
    dec_alu = 4'b0000;
    if (opcode == OP_R) begin
      dec_alu = alu_map(func3, func7b50[1]);
    end else if (opcode == OP_IMM) begin
      dec_alu = alu_map(func3, (func3 == 3'b101) && func7b50[1]);
    end
  end

  always_comb begin
    in_ready    = (state_q == S_EMPTY) || ((state_q == S_VALID) && out_ready);
    accept      = in_valid && in_ready;
    state_d     = state_q;
    cnt_d       = cnt_q;
    aluctl_d    = aluctl_q;
    mulctl_d    = mulctl_q;
    divctl_d    = divctl_q;
    sel_d       = sel_q;
    err_d       = err_q;
    wdiv_d      = wdiv_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (wdiv_q ? div_done : mul_done) begin
          state_d = S_VALID;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_VALID;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VALID: begin
        if (out_ready && !in_valid) state_d = S_EMPTY;
      end
      default: ;
    endcase

    // Accept is only possible from EMPTY/VALID, so it overrides the case above.
    if (accept) begin
      aluctl_d = dec_alu;
      mulctl_d = dec_mul ? func3[1:0] : 2'b00;
      divctl_d = dec_div ? func3[1:0] : 2'b00;
      err_d    = 1'b0;
      cnt_d    = '0;
      wdiv_d   = dec_div;
      sel_d    = SEL_ALU;
      state_d  = S_VALID;
      if (dec_mul) begin
        state_d     = S_WAIT;
        mul_start_d = 1'b1;
        sel_d       = SEL_MU;
      end else if (dec_div) begin
        if (DIV_OK) begin
          state_d     = S_WAIT;
          div_start_d = 1'b1;
          sel_d       = SEL_DU;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      aluctl_q    <= '0;
      mulctl_q    <= '0;
      divctl_q    <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      wdiv_q      <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aluctl_q    <= aluctl_d;
      mulctl_q    <= mulctl_d;
      divctl_q    <= divctl_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      wdiv_q      <= wdiv_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
    end
  end

  assign out_valid = (state_q == S_VALID);
  assign aluctl    = aluctl_q;
  assign mulctl    = mulctl_q;
  assign divctl    = divctl_q;
  assign ifuresctl = sel_q;
  assign err       = err_q;
  assign mul_start = mul_start_q;
  assign div_start = div_start_q;

endmodule

// File: doc/ex_sequencer.md
# ex_sequencer

Registered, handshaked successor to the combinational EX-stage controller for RV32IM. It decodes opcode/func3/func7 bits into ALU, multiplier and divider controls and holds one instruction in flight. Multi-cycle MUL/DIV operations are sequenced through a start/done handshake with a watchdog, and the block drives the result-mux select and a valid/ready handshake toward the MEM stage. It sits between the ID/EX pipeline register and the EX functional units (ALU, MU, DU).

## Interface
- `ifuresctl_N`, 3: number of result-mux sources; 0=ALU, 1=MU, 2=DU. DIV support requires ≥3.
- `WAIT_MAX`, 64: maximum cycles in WAIT before timeout; ≥1.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: block accepts instruction this cycle.
- `opcode` in 7: instruction[6:0].
- `func3` in 3: instruction[14:12].
- `func7b50` in 2: {instr[30], instr[25]}.
- `mul_done` in 1: MU result ready.
- `div_done` in 1: DU result ready.
- `mul_start` out 1: one-cycle MU launch pulse.
- `div_start` out 1: one-cycle DU launch pulse.
- `aluctl` out 4: ALU op.
- `mulctl` out 2: MU op.
- `divctl` out 2: DU op.
- `ifuresctl` out `$clog2(ifuresctl_N)`: result-mux select.
- `out_valid` out 1: result and controls valid toward MEM.
- `out_ready` in 1: downstream accepts.
- `err` out 1: held with `out_valid`; set on timeout or unsupported DIV.

## Operation
- **Decode classes:**
  - R-type (`0110011`) with `func7b50`=01 is M-extension. `func3[2]`=0 is MUL class with `mulctl`=`func3[1:0]`. `func3[2]`=1 is DIV class with `divctl`=`func3[1:0]`.
  - All other opcodes are ALU class.
- **`aluctl` encoding:** add 0000, sub 0001, xor 0010, or 0011, and 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
- **R-type (`func7b50`≠01):**
  - `func3` 000 gives {000,`func7b50[1]`}.
  - 101 gives {011,`func7b50[1]`}.
  - Others map per the encoding above.
- **OP-IMM (`0010011`):** same mapping, except 000 is always add. 101 uses `func7b50[1]` for srai.
- **Other opcodes:** `aluctl`=0000 (address add).
- **`ifuresctl`:** 0 for ALU class, 1 for MUL class, 2 for DIV class.
- **`ifuresctl_N`<3:** a DIV-class instruction completes as ALU class with `ifuresctl`=0 and `err`=1. It never pulses `div_start`.
- **States:** EMPTY, WAIT, VALID. A single instruction is in flight.
  - `in_ready` = (EMPTY) | (VALID & `out_ready`).
- **On accept (`in_valid` & `in_ready`):** all control outputs register the decode and `err` clears.
  - ALU class goes to VALID.
  - MUL/DIV class goes to WAIT, clears the counter, and pulses the matching start.
- **WAIT:**
  - The matching done (`mul_done` for MUL, `div_done` for DIV) is sampled every WAIT cycle. When it is 1, go to VALID.
  - Otherwise the counter increments. If the counter equals `WAIT_MAX`-1 without done, go to VALID with `err`=1.
  - The non-matching done is ignored.
- **VALID:**
  - If `out_ready` & `in_valid`, accept the next instruction (back-to-back).
  - If `out_ready` & !`in_valid`, go to EMPTY.
  - If !`out_ready`, hold all outputs.
- **Ignored inputs:** done inputs in EMPTY or VALID have no effect.
- **Output stability:** control outputs stay stable from accept until the VALID handshake completes. In EMPTY they retain their last value.
- **Counter width:** `$clog2(WAIT_MAX+1)`. It never wraps because timeout fires first.

## Timing
- **Reset:** state EMPTY. `aluctl`, `mulctl`, `divctl`, `ifuresctl`, `mul_start`, `div_start`, `out_valid`, `err` and the counter are all 0. `in_ready`=1 on the cycle after reset deasserts.
- **ALU op:** accepted in cycle N gives `out_valid`=1 in N+1.
- **MUL/DIV op:** accepted in cycle N gives start high in N+1 only. If done is high in cycle N+1+k (k≥0), `out_valid`=1 in N+2+k.
- **Timeout:** no done in cycles N+1..N+`WAIT_MAX` gives `out_valid`=1 and `err`=1 in N+1+`WAIT_MAX`.
- **Throughput:** back-to-back ALU ops sustain one per cycle while `out_ready`=1.
- **Reset mid-WAIT:** next state EMPTY, no further start pulse, late done ignored.
- **Reset mid-VALID:** `out_valid` drops the next cycle and the instruction is discarded.
- **Reset precedence:** `rst` overrides simultaneous accept, done, or timeout.

## Test plan
- **Reset, then one ALU op:** reset, then `opcode`=0110011, `func3`=000, `func7b50`=10 -> cycle+1: `out_valid`=1, `aluctl`=0001, `ifuresctl`=0, `err`=0.
- **Back-to-back ALU stream:** xor, or, and, sll with `out_ready`=1 -> `aluctl` 0010, 0011, 0100, 0101 on consecutive cycles with `in_ready` held 1.
- **MULHU:** `func7b50`=01, `func3`=011, `mul_done` high 3 cycles after the start pulse -> single `mul_start` pulse, `mulctl`=11, `in_ready`=0 during WAIT, then `out_valid`=1 with `ifuresctl`=1.
- **DIV timeout:** `WAIT_MAX`=4, REM (`func3`=110) with `div_done` never asserted -> `divctl`=10 and `out_valid`=1 with `err`=1 exactly 5 cycles after accept. A spurious `mul_done` during WAIT is ignored.
- **Downstream backpressure:** `out_ready`=0 for 3 cycles while VALID -> outputs held, `in_ready`=0, then the next instruction is accepted in the handshake cycle.
- **Reset mid-WAIT, and `ifuresctl_N`=2:**
  - `rst` asserted during WAIT, then `mul_done`=1 -> state EMPTY, `out_valid` stays 0.
  - With `ifuresctl_N`=2, a DIV instruction -> `out_valid` next cycle with `err`=1, `ifuresctl`=0, no `div_start`.
